uart_tx: RTL and testbench

//  Serial UART transmitter: 8N1 frames (start, 8 data LSB-first, stop) at a fixed bit period.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing and frame-length helpers.
// Used by uart_tx and its companion uart_rx.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP   = 3'd4;

    // 100 MHz system clock at 9600 baud
    localparam int DEF_CLKS_PER_BIT = 10417;
    localparam int DEF_DATA_WIDTH   = 8;

    // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_clks(input int clks_per_bit, input int data_width,
                                      input bit parity_en);
        return (data_width + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and wraps; tick marks the last cycle of a bit.
// clr holds the count at zero so the first bit after it starts on a clean boundary.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clr || tick)
            count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_l)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a send/ready handshake and a registered, idle-high tx line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic                  ready,
    output logic                  done,
    output logic                  tx
);

    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  accept;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign accept = send && ready_q;
    assign ready  = ready_q;
    assign done   = done_q;
    assign tx     = tx_q;

    // Timer is held in reset while idle so START always lasts a full bit period.
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_l (rst_l),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shreg_d   = d_in;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^d_in;
`endif
                end
            end
            START: begin
                if (tick)
                    state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick)
                    state_d = STOP;
            end
`endif
            STOP: begin
                if (tick)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so tx, ready and done come straight off flops.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_q == STOP) && tick;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: table-driven frames plus reset and back-to-back sequences.
// Expected bit patterns are hand-written; parity expectations apply when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;  // bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       send = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       ready, done, tx;

    int total = 0;
    int bad = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .send  (send),
        .d_in  (d_in),
        .ready (ready),
        .done  (done),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk(input logic [9:0] frame, input logic par);
`ifdef UART_TX_PARITY_EN
        return {1'b1, par, frame[8:1], 1'b0};
`else
        return {par & 1'b0, frame};
`endif
    endfunction

    // Caller has already driven send/d_in for the accepting edge. Ends positioned in the done cycle.
    task automatic check_frame(input string tag, input logic [10:0] exp, input logic [7:0] mid_d,
                               input logic hold);
        for (int c = 1; c <= FL; c++) begin
            step();
            if (c == 1) begin
                d_in = mid_d;
                send = hold;
            end
            if (!hold && c == 5) send = 1'b1;
            if (!hold && c == 6) send = 1'b0;
            chk({tag, ".tx"}, tx, exp[(c - 1) / CPB]);
            chk({tag, ".ready"}, ready, 1'b0);
            chk({tag, ".done"}, done, 1'b0);
        end
        step();
        chk({tag, ".done_pulse"}, done, 1'b1);
        chk({tag, ".ready_back"}, ready, 1'b1);
        chk({tag, ".tx_idle"}, tx, 1'b1);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{8'h41, 10'b1_01000001_0, 1'b0};
        tbl[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
        tbl[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        tbl[3] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        tbl[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
        tbl[5] = '{8'h03, 10'b1_00000011_0, 1'b0};
        tbl[6] = '{8'h80, 10'b1_10000000_0, 1'b1};
        tbl[7] = '{8'h01, 10'b1_00000001_0, 1'b1};

        // reset held 3 cycles, then idle
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.tx", tx, 1'b1);
            chk("rst.ready", ready, 1'b1);
            chk("rst.done", done, 1'b0);
        end
        rst_l = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle.tx", tx, 1'b1);
            chk("idle.ready", ready, 1'b1);
            chk("idle.done", done, 1'b0);
        end

        // table frames; d_in scrambled and a stray send pulsed mid-frame
        for (int i = 0; i < 8; i++) begin
            send = 1'b1;
            d_in = tbl[i].d;
            check_frame($sformatf("vec%0d", i), mk(tbl[i].frame, tbl[i].par), ~tbl[i].d, 1'b0);
            step();
            chk("gap.done", done, 1'b0);
            chk("gap.tx", tx, 1'b1);
            chk("gap.ready", ready, 1'b1);
        end

        // back-to-back: send held high, second byte accepted in the done cycle
        send = 1'b1;
        d_in = 8'h55;
        check_frame("b2b0", mk(10'b1_01010101_0, 1'b0), 8'hAA, 1'b1);
        check_frame("b2b1", mk(10'b1_10101010_0, 1'b0), 8'hAA, 1'b0);
        step();
        chk("b2b.idle", tx, 1'b1);

        // reset at cycle 18 of a 0x00 frame
        send = 1'b1;
        d_in = 8'h00;
        step();
        send = 1'b0;
        for (int c = 2; c <= 18; c++) step();
        chk("midrst.pre_tx", tx, 1'b0);
        chk("midrst.pre_ready", ready, 1'b0);
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        chk("midrst.tx", tx, 1'b1);
        chk("midrst.ready", ready, 1'b1);
        chk("midrst.done", done, 1'b0);
        for (int i = 0; i < 45; i++) begin
            step();
            chk("midrst.nodone", done, 1'b0);
            chk("midrst.idle_tx", tx, 1'b1);
        end
        send = 1'b1;
        d_in = 8'hFF;
        check_frame("postrst", mk(10'b1_11111111_0, 1'b0), 8'h00, 1'b0);

        // reset and send in the same cycle: byte discarded
        step();
        rst_l = 1'b0;
        send = 1'b1;
        d_in = 8'h3C;
        step();
        rst_l = 1'b1;
        send = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rstsend.tx", tx, 1'b1);
            chk("rstsend.ready", ready, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
